// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier arbiter: FSM state codes,
// the default operand width and the WAIT counter sizing rule.
package booth_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int DEF_N = 8;

  // The counter must hold TIMEOUT-1, which $clog2(TIMEOUT) bits always can.
  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Request, response and multiplier-side signals of the Booth multiplier arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface booth_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int N    = booth_pkg::DEF_N,
  parameter int ID_W = $clog2(NREQ)
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;

  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [2*N-1:0]    rsp_product;
  logic              rsp_ready;

  logic              mul_start;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic              mul_done;
  logic [2*N-1:0]    mul_product;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_product,
    output req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_a, mul_b
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, mul_done, mul_product,
    input  req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_a, mul_b
  );

endinterface

// File: rtl/booth_mul_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping.
// Purely combinational so any shared-resource arbiter can reuse it.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] id,
  output logic            any
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant = '0;
    id    = '0;
    any   = 1'b0;
    // Scan from the farthest offset back to ptr so the nearest valid one wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid[ID_W'((int'(ptr) + i) % NREQ)]) begin
        id  = ID_W'((int'(ptr) + i) % NREQ);
        any = 1'b1;
      end
    end
    grant[id] = any;
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one sequential Booth multiplier between NREQ requesters with
// round-robin arbitration, a tagged response channel and a WAIT timeout.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int N       = DEF_N,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  booth_mul_arbiter_if.master bus,
  output logic                busy,
  output logic                err,
  output logic [ID_W-1:0]     err_id
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [1:0]     state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [N-1:0]   op_a_q, op_a_d;
  logic [N-1:0]   op_b_q, op_b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [2*N-1:0] rsp_product_q, rsp_product_d;
  logic           err_q, err_d;
  logic [ID_W-1:0] err_id_q, err_id_d;

  logic [NREQ-1:0] pick_grant;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;
  logic [ID_W-1:0] gid_next;

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_rr_pick (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .id    (pick_id),
    .any   (pick_any)
  );

  assign gid_next = (gid_q == ID_W'(NREQ - 1)) ? '0 : gid_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gid_d         = gid_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    err_d         = 1'b0;
    err_id_d      = err_id_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          op_a_d  = bus.req_a[int'(pick_id) * N +: N];
          op_b_d  = bus.req_b[int'(pick_id) * N +: N];
          gid_d   = pick_id;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done arriving on the last counted cycle still wins over the timeout.
        if (bus.mul_done) begin
          rsp_product_d = bus.mul_product;
          rsp_id_d      = gid_q;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          err_id_d = gid_q;
          ptr_d    = gid_next;
          state_d  = S_IDLE;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = gid_next;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: operand and result registers are reset as well, because they drive
  // ports that must read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      gid_q         <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      err_q         <= 1'b0;
      err_id_q      <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gid_q         <= gid_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      err_q         <= err_d;
      err_id_q      <= err_id_d;
    end
  end

  // Grant is combinational on req_valid; gated by rst_n so it also reads 0 in reset.
  assign bus.req_ready   = (rst_n && state_q == S_IDLE) ? pick_grant : '0;
  assign bus.mul_start   = (state_q == S_START);
  assign bus.mul_a       = op_a_q;
  assign bus.mul_b       = op_b_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_product_q;
  assign busy            = (state_q != S_IDLE);
  assign err             = err_q;
  assign err_id          = err_id_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter with a cycle-accurate Booth
// multiplier model (done 2N+2 cycles after start) and a round-robin reference.
module tb_booth_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int N       = 8;
  localparam int TIMEOUT = 64;
  localparam int ID_W    = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            busy;
  logic            err;
  logic [ID_W-1:0] err_id;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [N-1:0]   op_a [NREQ];
  logic [N-1:0]   op_b [NREQ];
  logic [N-1:0]   exp_a, exp_b;
  logic [2*N-1:0] exp_p, last_p;
  int             cyc;
  int             ref_ptr;
  int             gid;
  bit             hang = 1'b0;
  bit             saw_rsp;

  booth_mul_arbiter_if #(.NREQ(NREQ), .N(N), .ID_W(ID_W)) bus ();

  booth_mul_arbiter #(.NREQ(NREQ), .N(N), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.master),
    .busy   (busy),
    .err    (err),
    .err_id (err_id)
  );

  always #5 clk = ~clk;

  // Multiplier model: latches operands on start, pulses done 2N+2 cycles later.
  logic         m_active;
  int           m_rem;
  logic [N-1:0] m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_rem    <= 0;
      m_a      <= '0;
      m_b      <= '0;
    end else if (bus.mul_start) begin
      m_active <= 1'b1;
      m_rem    <= 2 * N + 1;
      m_a      <= bus.mul_a;
      m_b      <= bus.mul_b;
    end else if (m_active) begin
      if (bus.mul_done) m_active <= 1'b0;
      else if (m_rem > 0) m_rem <= m_rem - 1;
    end
  end

  assign bus.mul_done    = m_active && (m_rem == 0) && !hang;
  assign bus.mul_product = $signed(m_a) * $signed(m_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid requester at or after p, wrapping.
  function automatic int ref_next(input logic [NREQ-1:0] v, input int p);
    for (int off = 0; off < NREQ; off++)
      if (v[(p + off) % NREQ]) return (p + off) % NREQ;
    return 0;
  endfunction

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    bus.req_a[i*N +: N] = a;
    bus.req_b[i*N +: N] = b;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"},   64'(bus.req_ready),   64'(0));
    check({tag, "_rsp_valid"},   64'(bus.rsp_valid),   64'(0));
    check({tag, "_rsp_id"},      64'(bus.rsp_id),      64'(0));
    check({tag, "_rsp_product"}, 64'(bus.rsp_product), 64'(0));
    check({tag, "_mul_start"},   64'(bus.mul_start),   64'(0));
    check({tag, "_mul_a"},       64'(bus.mul_a),       64'(0));
    check({tag, "_mul_b"},       64'(bus.mul_b),       64'(0));
    check({tag, "_busy"},        64'(busy),            64'(0));
    check({tag, "_err"},         64'(err),             64'(0));
    check({tag, "_err_id"},      64'(err_id),          64'(0));
  endtask

  // Waits (bounded) for a grant and checks it goes to exp_id only.
  task automatic accept(input int exp_id);
    int k = 0;
    #1;
    while (bus.req_ready == '0 && k < 50) begin
      @(negedge clk); #1; k++;
    end
    check("grant", 64'(bus.req_ready), 64'(NREQ'(1) << exp_id));
    check("grant_onehot", 64'($countones(bus.req_ready)), 64'(1));
    exp_a = op_a[exp_id];
    exp_b = op_b[exp_id];
    exp_p = $signed(exp_a) * $signed(exp_b);
    cyc   = 0;
  endtask

  // Follows one accepted operation to its response handshake.
  task automatic finish_op(input int exp_id, input bit drop, input int hold);
    @(negedge clk); cyc++;
    check("mul_start", 64'(bus.mul_start), 64'(1));
    check("mul_a", 64'(bus.mul_a), 64'(exp_a));
    check("mul_b", 64'(bus.mul_b), 64'(exp_b));
    if (drop) bus.req_valid &= ~(NREQ'(1) << exp_id);
    else set_op(exp_id, N'($urandom), N'($urandom));
    @(negedge clk); cyc++;
    check("mul_start_pulse", 64'(bus.mul_start), 64'(0));
    check("mul_a_stable", 64'(bus.mul_a), 64'(exp_a));
    while (!bus.rsp_valid && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    check("rsp_latency", 64'(cyc), 64'(2 * N + 4));
    check("rsp_id", 64'(bus.rsp_id), 64'(exp_id));
    check("rsp_product", 64'(bus.rsp_product), 64'(exp_p));
    last_p = bus.rsp_product;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.rsp_valid), 64'(1));
      check("hold_id", 64'(bus.rsp_id), 64'(exp_id));
      check("hold_product", 64'(bus.rsp_product), 64'(exp_p));
      check("hold_req_ready", 64'(bus.req_ready), 64'(0));
      check("hold_mul_start", 64'(bus.mul_start), 64'(0));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_released", 64'(bus.rsp_valid), 64'(0));
    ref_ptr = (exp_id + 1) % NREQ;
  endtask

  initial begin
    logic [N-1:0] xa [3];
    logic [N-1:0] xb [3];
    logic [2*N-1:0] xp [3];
    xa[0] = 8'h80; xb[0] = 8'h80; xp[0] = 16'h4000;
    xa[1] = 8'h80; xb[1] = 8'h7F; xp[1] = 16'hC080;
    xa[2] = 8'h00; xb[2] = 8'hFF; xp[2] = 16'h0000;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, '0, '0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    ref_ptr = 0;
    @(negedge clk);

    // 7 * -3 on requester 0
    set_op(0, 8'd7, 8'hFD);
    bus.req_valid = 4'b0001;
    accept(0);
    finish_op(0, 1'b1, 0);
    check("basic_literal", 64'(last_p), 64'(16'hFFEB));

    // All requesters valid from reset: grant order 0,1,2,3,0
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, N'($urandom), N'($urandom));
    bus.req_valid = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    ref_ptr = 0;
    for (int k = 0; k < 5; k++) begin
      gid = ref_next(bus.req_valid, ref_ptr);
      accept(gid);
      finish_op(gid, 1'b0, 0);
    end
    bus.req_valid = '0;
    @(negedge clk);

    // Backpressure: rsp_ready low for 10 cycles
    bus.rsp_ready = 1'b0;
    set_op(1, N'($urandom), N'($urandom));
    bus.req_valid = 4'b0010;
    accept(ref_next(bus.req_valid, ref_ptr));
    finish_op(1, 1'b1, 10);

    // Operand extremes
    for (int k = 0; k < 3; k++) begin
      set_op(2, xa[k], xb[k]);
      bus.req_valid = 4'b0100;
      accept(2);
      finish_op(2, 1'b1, 0);
      check("extreme_literal", 64'(last_p), 64'(xp[k]));
    end

    // Timeout: multiplier never answers requester 2
    hang = 1'b1;
    set_op(2, N'($urandom), N'($urandom));
    bus.req_valid = 4'b0100;
    accept(ref_next(bus.req_valid, ref_ptr));
    saw_rsp = 1'b0;
    while (!err && cyc < 200) begin
      @(negedge clk); cyc++;
      if (cyc == 1) bus.req_valid = '0;
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    check("err_latency", 64'(cyc), 64'(TIMEOUT + 2));
    check("err_id", 64'(err_id), 64'(2));
    check("err_idle", 64'(busy), 64'(0));
    check("err_no_rsp", 64'(saw_rsp), 64'(0));
    ref_ptr = 3;
    hang = 1'b0;
    @(negedge clk);
    check("err_pulse", 64'(err), 64'(0));
    check("stale_done_ignored", 64'(bus.rsp_valid | busy), 64'(0));
    set_op(0, N'($urandom), N'($urandom));
    set_op(3, N'($urandom), N'($urandom));
    bus.req_valid = 4'b1001;
    gid = ref_next(bus.req_valid, ref_ptr);
    accept(gid);
    finish_op(gid, 1'b1, 0);
    gid = ref_next(bus.req_valid, ref_ptr);
    accept(gid);
    finish_op(gid, 1'b1, 0);

    // Reset asserted mid-WAIT
    set_op(1, N'($urandom), N'($urandom));
    bus.req_valid = 4'b0010;
    accept(ref_next(bus.req_valid, ref_ptr));
    @(negedge clk);
    bus.req_valid = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    set_op(1, 8'd5, 8'd5);
    bus.req_valid = 4'b0010;
    #1;
    check_zero("midwait_reset");
    @(negedge clk);
    rst_n = 1'b1;
    ref_ptr = 0;
    accept(ref_next(bus.req_valid, ref_ptr));
    finish_op(1, 1'b1, 0);
    check("after_reset_literal", 64'(last_p), 64'(25));
    saw_rsp = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    check("no_spurious_rsp", 64'(saw_rsp), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
